timing_peak_detect: RTL

TIMING_PEAK_DETECT -- requirements
Module: timing_peak_detect

---
 rtl/timing_peak_detect.sv | 129 ++++++++++++
 1 files changed

// File: rtl/timing_peak_detect.sv
// timing_peak_detect: thresholded correlation arming, windowed peak search, one-cycle report and blanking
module timing_peak_detect #(
    parameter int unsigned THR   = 6,
    parameter int unsigned SH    = 3,
    parameter int unsigned HOLD  = 4,
    parameter int unsigned WIN   = 32,
    parameter int unsigned BLANK = 160,
    parameter int unsigned MIN_R = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [22:0] p_sum,
    input  logic [22:0] r_sum,
    output logic        det,
    output logic [15:0] peak_idx,
    output logic [22:0] peak_val,
    output logic [1:0]  state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEAK  = 2'd1;
    localparam logic [1:0] S_REP   = 2'd2;
    localparam logic [1:0] S_BLANK = 2'd3;
    localparam int PW = 27 + SH;

    logic [1:0]    state_q, state_d;
    logic [15:0]   sidx_q, sidx_d;
    logic [15:0]   hold_cnt_q, hold_cnt_d;
    logic [15:0]   win_cnt_q, win_cnt_d;
    logic [15:0]   blank_cnt_q, blank_cnt_d;
    logic [22:0]   max_q, max_d;
    logic [15:0]   max_idx_q, max_idx_d;
    logic          det_q, det_d;
    logic [15:0]   peak_idx_q, peak_idx_d;
    logic [22:0]   peak_val_q, peak_val_d;
    logic [22:0]   p_pos, r_pos;
    logic [PW-1:0] p_scl, r_scl;
    logic          hit;

    // Both sides widened so the ratio test is exact for any 23-bit input
    always_comb begin
        p_pos = p_sum[22] ? '0 : p_sum;
        r_pos = r_sum[22] ? '0 : r_sum;
        p_scl = PW'(p_pos) << SH;
        r_scl = PW'(r_pos) * PW'(THR);
        hit   = (r_pos >= 23'(MIN_R)) && (p_scl >= r_scl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sidx_q      <= '0;
            hold_cnt_q  <= '0;
            win_cnt_q   <= '0;
            blank_cnt_q <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            det_q       <= 1'b0;
            peak_idx_q  <= '0;
            peak_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            sidx_q      <= sidx_d;
            hold_cnt_q  <= hold_cnt_d;
            win_cnt_q   <= win_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            det_q       <= det_d;
            peak_idx_q  <= peak_idx_d;
            peak_val_q  <= peak_val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (ena && hit && hold_cnt_q == 16'(HOLD - 1)) ? S_PEAK : S_IDLE;
            S_PEAK:  state_d = (ena && win_cnt_q == 16'(WIN - 1)) ? S_REP : S_PEAK;
            S_REP:   state_d = S_BLANK;
            default: state_d = (ena && blank_cnt_q == 16'(BLANK - 1)) ? S_IDLE : S_BLANK;
        endcase
    end

    // REPORT does not consume a sample, so the index only advances elsewhere
    always_comb begin
        sidx_d      = (ena && state_q != S_REP) ? sidx_q + 16'd1 : sidx_q;
        hold_cnt_d  = hold_cnt_q;
        win_cnt_d   = win_cnt_q;
        blank_cnt_d = blank_cnt_q;
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    hold_cnt_d = (!hit || state_d == S_PEAK) ? '0 : hold_cnt_q + 16'd1;
                    max_d      = (state_d == S_PEAK) ? p_pos : max_q;
                    max_idx_d  = (state_d == S_PEAK) ? sidx_q : max_idx_q;
                    win_cnt_d  = (state_d == S_PEAK) ? 16'd1 : win_cnt_q;
                end
            end
            S_PEAK: begin
                if (ena) begin
                    max_d     = (p_pos > max_q) ? p_pos : max_q;
                    max_idx_d = (p_pos > max_q) ? sidx_q : max_idx_q;
                    win_cnt_d = win_cnt_q + 16'd1;
                end
            end
            S_REP: blank_cnt_d = '0;
            default: begin
                if (ena) begin
                    blank_cnt_d = blank_cnt_q + 16'd1;
                    hold_cnt_d  = (state_d == S_IDLE) ? '0 : hold_cnt_q;
                end
            end
        endcase
    end

    always_comb begin
        det_d      = (state_d == S_REP);
        peak_idx_d = det_d ? max_idx_d : peak_idx_q;
        peak_val_d = det_d ? max_d : peak_val_q;
    end

    assign det      = det_q;
    assign peak_idx = peak_idx_q;
    assign peak_val = peak_val_q;
    assign state    = state_q;
endmodule
